// File: rtl/cpu_boot_harness.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : cpu_boot_harness
// Purpose  : Streams a program into instruction memory over valid/ready,
//            holds the CPU in reset while loading, then releases it for a
//            bounded run window and flags completion.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_boot_harness #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned RST_HOLD  = 2,
  parameter int unsigned RUN_LIMIT = 16,
  localparam int unsigned ADDR_W   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              s_valid,
  input  logic [XLEN-1:0]   s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [XLEN-1:0]   imem_wdata,
  output logic              cpu_rst,
  output logic [ADDR_W:0]   load_count,
  output logic [31:0]       cycle_count,
  output logic              ovf,
  output logic              done
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_HOLD = 3'd2,
    ST_RUN  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // Index of the last memory word; accepting it always ends the load.
  localparam logic [ADDR_W:0] c_LAST_IDX = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [31:0]     c_HOLD_END = 32'(RST_HOLD - 1);
  localparam logic [31:0]     c_RUN_END  = 32'(RUN_LIMIT - 1);

  state_t            r_state;
  logic              r_s_ready;
  logic              r_imem_we;
  logic [ADDR_W-1:0] r_imem_addr;
  logic [XLEN-1:0]   r_imem_wdata;
  logic              r_cpu_rst;
  logic [ADDR_W:0]   r_load_count;
  logic [31:0]       r_cycle_count;
  logic [31:0]       r_hold_cnt;
  logic              r_ovf;
  logic              r_done;

  logic              w_accept;
  logic              w_final;

  assign w_accept = s_valid & r_s_ready;
  // The load ends on s_last or when memory is full, whichever comes first.
  assign w_final  = s_last | (r_load_count == c_LAST_IDX);

  assign s_ready     = r_s_ready;
  assign imem_we     = r_imem_we;
  assign imem_addr   = r_imem_addr;
  assign imem_wdata  = r_imem_wdata;
  assign cpu_rst     = r_cpu_rst;
  assign load_count  = r_load_count;
  assign cycle_count = r_cycle_count;
  assign ovf         = r_ovf;
  assign done        = r_done;

  // Sequencer: load -> reset hold -> bounded run -> done, all outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_s_ready     <= 1'b0;
      r_imem_we     <= 1'b0;
      r_imem_addr   <= '0;
      r_imem_wdata  <= '0;
      r_cpu_rst     <= 1'b1;
      r_load_count  <= '0;
      r_cycle_count <= '0;
      r_hold_cnt    <= '0;
      r_ovf         <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      // Write strobe is a single-cycle echo of an accept.
      r_imem_we <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state       <= ST_LOAD;
            r_s_ready     <= 1'b1;
            r_load_count  <= '0;
            r_cycle_count <= '0;
            r_ovf         <= 1'b0;
            r_done        <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (w_accept) begin
            r_imem_we    <= 1'b1;
            r_imem_addr  <= r_load_count[ADDR_W-1:0];
            r_imem_wdata <= s_data;
            r_load_count <= r_load_count + (ADDR_W+1)'(1);
            if (w_final) begin
              r_state    <= ST_HOLD;
              r_s_ready  <= 1'b0;
              r_hold_cnt <= '0;
              // Filling memory without an s_last means the program was truncated.
              r_ovf      <= ~s_last;
            end
          end
        end
        ST_HOLD: begin
          if (r_hold_cnt == c_HOLD_END) begin
            r_state   <= ST_RUN;
            r_cpu_rst <= 1'b0;
          end else begin
            r_hold_cnt <= r_hold_cnt + 32'd1;
          end
        end
        ST_RUN: begin
          r_cycle_count <= r_cycle_count + 32'd1;
          if (r_cycle_count == c_RUN_END) begin
            r_state   <= ST_DONE;
            r_cpu_rst <= 1'b1;
            r_done    <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_boot_harness.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_cpu_boot_harness
// Purpose  : Scoreboard bench for cpu_boot_harness. Instance 0 uses the
//            default geometry (DEPTH 64, RST_HOLD 2, RUN_LIMIT 16); instance 1
//            is small (DEPTH 4, RST_HOLD 1, RUN_LIMIT 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_boot_harness;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start   [2];
  logic        s_valid [2];
  logic        s_last  [2];
  logic [31:0] s_data  [2];
  logic        s_ready [2];
  logic        we      [2];
  logic        cpu_rst [2];
  logic        ovf     [2];
  logic        done    [2];
  logic [31:0] wd      [2];
  logic [31:0] cc      [2];
  logic [31:0] addr    [2];
  logic [31:0] lc      [2];

  logic [5:0] a0;
  logic [6:0] lc0;
  logic [1:0] a1;
  logic [2:0] lc1;

  assign addr[0] = {26'd0, a0};
  assign lc[0]   = {25'd0, lc0};
  assign addr[1] = {30'd0, a1};
  assign lc[1]   = {29'd0, lc1};

  cpu_boot_harness #(.XLEN(32), .DEPTH(64), .RST_HOLD(2), .RUN_LIMIT(16)) u_main (
    .clk(clk), .rst(rst), .start(start[0]), .s_valid(s_valid[0]), .s_data(s_data[0]),
    .s_last(s_last[0]), .s_ready(s_ready[0]), .imem_we(we[0]), .imem_addr(a0),
    .imem_wdata(wd[0]), .cpu_rst(cpu_rst[0]), .load_count(lc0), .cycle_count(cc[0]),
    .ovf(ovf[0]), .done(done[0])
  );

  cpu_boot_harness #(.XLEN(32), .DEPTH(4), .RST_HOLD(1), .RUN_LIMIT(4)) u_small (
    .clk(clk), .rst(rst), .start(start[1]), .s_valid(s_valid[1]), .s_data(s_data[1]),
    .s_last(s_last[1]), .s_ready(s_ready[1]), .imem_we(we[1]), .imem_addr(a1),
    .imem_wdata(wd[1]), .cpu_rst(cpu_rst[1]), .load_count(lc1), .cycle_count(cc[1]),
    .ovf(ovf[1]), .done(done[1])
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t m_e;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [31:0] prog [7] = '{32'h00a00093, 32'h00300113, 32'h002081b3, 32'h40208233,
                            32'h0020f2b3, 32'h0020e333, 32'h0020c3b3};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write, in the expected cycle.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (we[k] === 1'b1) begin
        if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
          check("spurious_write", 32'd1, 32'd0);
        end else begin
          if (k == 0) m_e = q0.pop_front();
          else        m_e = q1.pop_front();
          check("write_addr",  addr[k], m_e.addr);
          check("write_data",  wd[k],   m_e.data);
          check("write_cycle", 32'(cyc), 32'(m_e.cyc));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int k, input int idx, input logic [31:0] d);
    exp_t e;
    e.addr = 32'(idx);
    e.data = d;
    e.cyc  = cyc;
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic do_start(input int k);
    start[k] = 1'b1;
    tick();
    start[k] = 1'b0;
    check("ready_on_load",   32'(s_ready[k]), 32'd1);
    check("done_cleared",    32'(done[k]),    32'd0);
    check("ovf_cleared",     32'(ovf[k]),     32'd0);
    check("load_cnt_clear",  lc[k],           32'd0);
    check("cycle_cnt_clear", cc[k],           32'd0);
  endtask

  // Offers n words; words at index >= depth must be refused and stay offered.
  task automatic send(input int k, input int n, input int depth, input bit use_last, input bit gaps);
    int acc;
    acc = 0;
    for (int i = 0; i < n; i++) begin
      if (gaps && i > 0) begin
        s_valid[k] = 1'b0;
        tick();
      end
      s_valid[k] = 1'b1;
      s_data[k]  = prog[i];
      s_last[k]  = use_last && (i == n - 1);
      if (i < depth) begin
        check("s_ready_load", 32'(s_ready[k]), 32'd1);
        tick();
        push(k, i, prog[i]);
        acc++;
      end else begin
        check("s_ready_full", 32'(s_ready[k]), 32'd0);
      end
    end
    if (acc == n) begin
      s_valid[k] = 1'b0;
      s_last[k]  = 1'b0;
    end
  endtask

  task automatic run_check(input int k, input int exp_acc, input int exp_ovf,
                           input int hold, input int lim, input bit pulse_start);
    int h;
    int l;
    h = 0;
    l = 0;
    check("load_count",   lc[k],            32'(exp_acc));
    check("ovf_after",    32'(ovf[k]),      32'(exp_ovf));
    check("cpu_rst_hold", 32'(cpu_rst[k]),  32'd1);
    while (cpu_rst[k] === 1'b1 && h < 100) begin
      h++;
      tick();
    end
    check("hold_cycles", 32'(h), 32'(hold));
    while (cpu_rst[k] === 1'b0 && l < 100) begin
      l++;
      if (pulse_start && l == 3) start[k] = 1'b1;
      tick();
      start[k] = 1'b0;
    end
    check("run_cycles",    32'(l),       32'(lim));
    check("done_set",      32'(done[k]), 32'd1);
    check("cycle_final",   cc[k],        32'(lim));
    check("load_cnt_hold", lc[k],        32'(exp_acc));
    s_valid[k] = 1'b0;
    s_last[k]  = 1'b0;
    tick();
    check("done_sticky",   32'(done[k]),    32'd1);
    check("ovf_sticky",    32'(ovf[k]),     32'(exp_ovf));
    check("cycle_holds",   cc[k],           32'(lim));
    check("cpu_rst_done",  32'(cpu_rst[k]), 32'd1);
    check("sb_drain", 32'((k == 0) ? q0.size() : q1.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      start[k] = 1'b0; s_valid[k] = 1'b0; s_last[k] = 1'b0; s_data[k] = '0;
    end

    // Reset state
    #2 rst = 1'b0;
    #1;
    check("rst_s_ready",   32'(s_ready[0]), 32'd0);
    check("rst_imem_we",   32'(we[0]),      32'd0);
    check("rst_addr",      addr[0],         32'd0);
    check("rst_wdata",     wd[0],           32'd0);
    check("rst_cpu_rst",   32'(cpu_rst[0]), 32'd1);
    check("rst_load_cnt",  lc[0],           32'd0);
    check("rst_cycle_cnt", cc[0],           32'd0);
    check("rst_ovf",       32'(ovf[0]),     32'd0);
    check("rst_done",      32'(done[0]),    32'd0);
    check("rst_cpu_rst_s", 32'(cpu_rst[1]), 32'd1);
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("idle_cpu_rst", 32'(cpu_rst[0]), 32'd1);

    // 7-word program, full-rate stream
    do_start(0);
    send(0, 7, 64, 1'b1, 1'b0);
    run_check(0, 7, 0, 2, 16, 1'b0);

    // Same program with gaps; start pulsed during RUN must be ignored
    do_start(0);
    send(0, 7, 64, 1'b1, 1'b1);
    run_check(0, 7, 0, 2, 16, 1'b1);

    // Reload from DONE with a 3-word program
    do_start(0);
    send(0, 3, 64, 1'b1, 1'b0);
    run_check(0, 3, 0, 2, 16, 1'b0);

    // Asynchronous reset in the middle of RUN
    do_start(0);
    send(0, 3, 64, 1'b1, 1'b0);
    w = 0;
    while (cpu_rst[0] === 1'b1 && w < 100) begin
      w++;
      tick();
    end
    check("reached_run", 32'(cpu_rst[0]), 32'd0);
    tick(); tick(); tick(); tick();
    #2 rst = 1'b0;
    #1;
    check("midrun_cpu_rst",  32'(cpu_rst[0]), 32'd1);
    check("midrun_cycle",    cc[0],           32'd0);
    check("midrun_we",       32'(we[0]),      32'd0);
    check("midrun_s_ready",  32'(s_ready[0]), 32'd0);
    check("midrun_load_cnt", lc[0],           32'd0);
    #7 rst = 1'b1;
    s_valid[0] = 1'b1;
    s_data[0]  = 32'hdeadbeef;
    for (int i = 0; i < 5; i++) tick();
    check("idle_no_ready",    32'(s_ready[0]), 32'd0);
    check("idle_no_load",     lc[0],           32'd0);
    check("idle_cpu_rst_rst", 32'(cpu_rst[0]), 32'd1);
    s_valid[0] = 1'b0;
    tick();

    // Single word with s_last on the small instance (RST_HOLD 1)
    do_start(1);
    send(1, 1, 4, 1'b1, 1'b0);
    run_check(1, 1, 0, 1, 4, 1'b0);

    // Overflow: DEPTH 4, five words offered, no s_last
    do_start(1);
    send(1, 5, 4, 1'b0, 1'b0);
    run_check(1, 4, 1, 1, 4, 1'b0);

    tick();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
